// File: rtl/OoO_pkg.sv
// OoO_pkg: shared types for the out-of-order core's multiply/divide unit.
//   TAG_W           - width of the reorder-buffer tag carried with each op
//   div_op_t        - DIV / DIVU / REM / REMU selector
//   mdu_div_state_t - states of the sequential divider
//   mdu2alu_t       - operands the MDU drives onto the shared ALU adder
//   alu2mdu_t       - shared ALU adder result fed back to the MDU
package OoO_pkg;

  localparam int TAG_W = 6;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_ITER = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_div_state_t;

  typedef struct packed {
    logic [32:0] a;
    logic [32:0] b;
  } mdu2alu_t;

  typedef struct packed {
    logic [33:0] res;
    logic        not_zero;
  } alu2mdu_t;

  // Signed flavours need operand/result sign handling.
  function automatic logic isSignedOp(input div_op_t op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  // Remainder flavours return the remainder instead of the quotient.
  function automatic logic isRemOp(input div_op_t op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  function automatic logic [31:0] negate32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/mdu_adder_arb.sv
// mdu_adder_arb: arbitrates the single ALU adder between regular ALU issue
// and the sequential divider. Regular ops win by default; once the divider
// has been denied STARVE_LIMIT cycles in a row it takes the adder.
//   clock, reset      - clock and async active-high reset
//   want_i            - divider needs the adder this cycle
//   alu_issue_req_i   - a regular ALU op needs the adder this cycle
//   mdu_grant_o       - divider owns the adder this cycle
//   alu_issue_gnt_o   - regular ALU op may use the adder this cycle
module mdu_adder_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic want_i,
  input  logic alu_issue_req_i,
  output logic mdu_grant_o,
  output logic alu_issue_gnt_o
);

  localparam int CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q, starve_d;

  assign mdu_grant_o     = want_i & (~alu_issue_req_i | (starve_q == Limit));
  assign alu_issue_gnt_o = alu_issue_req_i & ~mdu_grant_o;

  // The starve counter only measures an unbroken run of denied cycles, so
  // any grant or any cycle without demand restarts it; it saturates so the
  // divider keeps priority until it is actually served.
  always_comb begin
    starve_d = starve_q;
    if (!want_i || mdu_grant_o) begin
      starve_d = '0;
    end else if (starve_q != Limit) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mdu_div_seq.sv
// mdu_div_seq: 32-bit sequential restoring divider that borrows the shared
// ALU adder for its subtract steps and for the final sign fix-up.
//   clock, reset               - clock and async active-high reset
//   req_valid/req_ready        - request handshake (ready only in IDLE)
//   req_op/req_a/req_b/req_tag - operation, dividend, divisor, ROB tag
//   resp_valid/resp_ready      - response handshake, held in DONE
//   resp_data/resp_tag         - result and its ROB tag
//   flush                      - kills any in-flight operation
//   alu_issue_req/alu_issue_gnt- regular ALU demand and its grant
//   mdu_valid                  - ALU adder operand mux select
//   mdu2alu/alu2mdu            - operands to and result from the ALU adder
module mdu_div_seq
  import OoO_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  div_op_t          req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  input  logic             flush,
  input  logic             alu_issue_req,
  output logic             alu_issue_gnt,
  output logic             mdu_valid,
  output mdu2alu_t         mdu2alu,
  input  alu2mdu_t         alu2mdu
);

  mdu_div_state_t   state_q, state_d;
  div_op_t          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      dvd_q, dvd_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      result_q, result_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic        wantAdder, mduGrant;
  logic        aNeg, bNeg;
  logic [31:0] aAbs, bAbs;
  logic [32:0] partial;
  logic        stepOk;
  logic [31:0] stepRem, stepQuo;
  logic        unusedBits;

  assign wantAdder = (state_q == MDU_ITER) || (state_q == MDU_FIX);

  mdu_adder_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clock          (clock),
    .reset          (reset),
    .want_i         (wantAdder),
    .alu_issue_req_i(alu_issue_req),
    .mdu_grant_o    (mduGrant),
    .alu_issue_gnt_o(alu_issue_gnt)
  );

  assign mdu_valid  = mduGrant;
  assign req_ready  = (state_q == MDU_IDLE);
  assign resp_valid = (state_q == MDU_DONE);
  assign resp_data  = result_q;
  assign resp_tag   = tag_q;

  // Operand magnitudes are formed locally so the adder is never needed at
  // accept time; 0x80000000 maps onto itself, which is the right magnitude.
  assign aNeg = isSignedOp(req_op) & req_a[31];
  assign bNeg = isSignedOp(req_op) & req_b[31];
  assign aAbs = aNeg ? negate32(req_a) : req_a;
  assign bAbs = bNeg ? negate32(req_b) : req_b;

  // One restoring step: the shifted partial remainder is 33 bits wide, and
  // its top bit alone guarantees the subtract fits. The adder computes
  // 2*(partial - divisor) via the trailing-one carry trick, so res[33] is
  // the no-borrow flag and res[32:1] the difference.
  assign partial = {rem_q, dvd_q[31]};
  assign stepOk  = partial[32] | alu2mdu.res[33];
  assign stepRem = stepOk ? alu2mdu.res[32:1] : partial[31:0];
  assign stepQuo = {quo_q[30:0], stepOk};

  assign unusedBits = ^{alu2mdu.not_zero, alu2mdu.res[0], quo_q[31]};

  // Drive the shared adder only on granted cycles so the ALU operand bus
  // stays quiet otherwise. FIX negates via ~x + 1 using the same trick.
  always_comb begin
    mdu2alu = '0;
    if (mduGrant) begin
      if (state_q == MDU_FIX) begin
        mdu2alu.a = {~result_q, 1'b1};
        mdu2alu.b = 33'h1;
      end else begin
        mdu2alu.a = {partial[31:0], 1'b1};
        mdu2alu.b = {~dvs_q, 1'b1};
      end
    end
  end

  // Next-state and datapath update. Everything holds unless the FSM state
  // explicitly advances; ungranted ITER/FIX cycles therefore stall cleanly.
  // Flush overrides any transition, including accepts and response handoff.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    case (state_q)
      MDU_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          tag_d = req_tag;
          dvd_d = aAbs;
          dvs_d = bAbs;
          quo_d = '0;
          rem_d = '0;
          cnt_d = '0;
          neg_d = isSignedOp(req_op) & (isRemOp(req_op) ? aNeg : (aNeg ^ bNeg));
          if (req_b == 32'h0) begin
            result_d = isRemOp(req_op) ? req_a : 32'hFFFF_FFFF;
            state_d  = MDU_DONE;
          end else if (isSignedOp(req_op) && (req_a == 32'h8000_0000) &&
                       (req_b == 32'hFFFF_FFFF)) begin
            result_d = isRemOp(req_op) ? 32'h0 : 32'h8000_0000;
            state_d  = MDU_DONE;
          end else begin
            state_d = MDU_ITER;
          end
        end
      end
      MDU_ITER: begin
        if (mduGrant) begin
          rem_d = stepRem;
          quo_d = stepQuo;
          dvd_d = {dvd_q[30:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_d = isRemOp(op_q) ? stepRem : stepQuo;
            state_d  = neg_q ? MDU_FIX : MDU_DONE;
          end
        end
      end
      MDU_FIX: begin
        if (mduGrant) begin
          result_d = alu2mdu.res[32:1];
          state_d  = MDU_DONE;
        end
      end
      MDU_DONE: begin
        if (resp_ready) begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase

    if (flush) begin
      state_d = MDU_IDLE;
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= MDU_IDLE;
      op_q     <= DIV_OP_DIV;
      tag_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_mdu_div_seq.sv
// tb_mdu_div_seq: scoreboard bench for mdu_div_seq. Requests push their
// hand-computed response into a queue; an independent monitor pops and
// compares data, tag and accept-to-valid latency whenever a response shows.
module tb_mdu_div_seq;
  import OoO_pkg::*;

  logic             clock;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  div_op_t          req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             flush;
  logic             alu_issue_req;
  logic             alu_issue_gnt;
  logic             mdu_valid;
  mdu2alu_t         mdu2alu;
  alu2mdu_t         alu2mdu;
  logic [33:0]      aluSum;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               acceptCyc;
    int               lat;
  } exp_t;

  typedef struct {
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    int          lat;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lastAcceptCyc = 0;
  int firstValidCyc = 0;
  bit prevValid = 1'b0;
  int mvCount = 0;
  int mdu2aluViol = 0;
  int gntViol = 0;
  int spacingViol = 0;
  bit starveTest = 1'b0;
  int lastGrant = 0;

  mdu_div_seq #(.STARVE_LIMIT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_tag     (resp_tag),
    .flush        (flush),
    .alu_issue_req(alu_issue_req),
    .alu_issue_gnt(alu_issue_gnt),
    .mdu_valid    (mdu_valid),
    .mdu2alu      (mdu2alu),
    .alu2mdu      (alu2mdu)
  );

  // Behavioural stand-in for the shared ALU adder.
  assign aluSum  = {1'b0, mdu2alu.a} + {1'b0, mdu2alu.b};
  assign alu2mdu = {aluSum, |aluSum};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%h want=0x%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Presents one request, waits (bounded) for acceptance and, when a
  // response is expected, records it in the scoreboard.
  task automatic applyStimulus(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag, input logic [31:0] expData,
                               input int expLat, input bit expectResp);
    int guard = 0;
    exp_t e;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(negedge clock);
    while (!req_ready && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    lastAcceptCyc = cyc;
    if (expectResp) begin
      e.data = expData;
      e.tag = tag;
      e.acceptCyc = cyc;
      e.lat = expLat;
      sbQ.push_back(e);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int g = 0;
    while ((sbQ.size() != 0 || !req_ready) && g < 500) begin
      @(negedge clock);
      g++;
    end
    if (g >= 500) checkOutput("idle_timeout", 32'(sbQ.size()), 32'd0);
  endtask

  // Response monitor: any valid response must match the scoreboard head,
  // every cycle it is presented; latency is judged on the handshake.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prevValid = 1'b0;
      end else begin
        if (resp_valid) begin
          if (!prevValid) firstValidCyc = cyc;
          if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_resp: got data=0x%h tag=%0d want no response",
                     resp_data, resp_tag);
          end else begin
            checkOutput("resp_data", resp_data, sbQ[0].data);
            checkOutput("resp_tag", 32'(resp_tag), 32'(sbQ[0].tag));
            if (resp_ready) begin
              checkOutput("latency", 32'(firstValidCyc - sbQ[0].acceptCyc), 32'(sbQ[0].lat));
              void'(sbQ.pop_front());
            end
          end
        end
        prevValid = resp_valid && !resp_ready;
      end
    end
  end

  // Continuous adder-interface invariants, tallied and judged at the end.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (!mdu_valid && mdu2alu != '0) mdu2aluViol++;
        if (alu_issue_gnt !== (alu_issue_req & ~mdu_valid)) gntViol++;
        if (mdu_valid) begin
          mvCount++;
          if (starveTest) begin
            if (cyc - lastGrant != 5) spacingViol++;
            lastGrant = cyc;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = DIV_OP_DIV;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    resp_ready = 1'b1;
    flush = 1'b0;
    alu_issue_req = 1'b1;

    repeat (3) @(negedge clock);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_mdu_valid", 32'(mdu_valid), 32'd0);
    checkOutput("rst_alu_gnt", 32'(alu_issue_gnt), 32'd1);
    checkOutput("rst_mdu2alu_a", mdu2alu.a[31:0], 32'd0);
    #2 reset = 1'b0;
    alu_issue_req = 1'b0;

    vecs.push_back('{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34});
    vecs.push_back('{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34});
    vecs.push_back('{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34});
    vecs.push_back('{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33});
    vecs.push_back('{DIV_OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33});
    vecs.push_back('{DIV_OP_DIVU, 32'd0,          32'd5,          32'd0,          33});
    vecs.push_back('{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{DIV_OP_REM,  32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{DIV_OP_REMU, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1});
    vecs.push_back('{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
    vecs.push_back('{DIV_OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  34});

    // Uncontended directed vectors: adder use is 32 steps plus one for FIX.
    foreach (vecs[i]) begin
      mvCount = 0;
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 1), vecs[i].data,
                    vecs[i].lat, 1'b1);
      waitIdle();
      checkOutput("mdu_valid_cycles", 32'(mvCount),
                  (vecs[i].lat == 1) ? 32'd0 : 32'(vecs[i].lat - 1));
    end

    // Contended: divider only wins every fifth cycle.
    @(posedge clock);
    #1;
    alu_issue_req = 1'b1;
    mvCount = 0;
    starveTest = 1'b1;
    applyStimulus(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, TAG_W'(20), 32'd1, 161, 1'b1);
    lastGrant = lastAcceptCyc;
    waitIdle();
    starveTest = 1'b0;
    checkOutput("starve_grants", 32'(mvCount), 32'd32);
    checkOutput("starve_spacing", 32'(spacingViol), 32'd0);
    @(posedge clock);
    #1;
    alu_issue_req = 1'b0;

    // Flush mid-ITER, then a fresh op must complete normally.
    applyStimulus(DIV_OP_DIVU, 32'd1000, 32'd7, TAG_W'(5), 32'd0, 0, 1'b0);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    @(negedge clock);
    checkOutput("flush_req_ready", 32'(req_ready), 32'd1);
    checkOutput("flush_resp_valid", 32'(resp_valid), 32'd0);
    applyStimulus(DIV_OP_DIVU, 32'd9, 32'd3, TAG_W'(9), 32'd3, 33, 1'b1);
    waitIdle();

    // Backpressure: response must stay presented while resp_ready is low.
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    applyStimulus(DIV_OP_DIVU, 32'd50, 32'd5, TAG_W'(3), 32'd10, 33, 1'b1);
    begin
      int g = 0;
      while (!resp_valid && g < 100) begin
        @(negedge clock);
        g++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput("hold_valid", 32'(resp_valid), 32'd1);
    end
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    waitIdle();

    // Reset mid-ITER discards the operation without a response.
    applyStimulus(DIV_OP_DIV, 32'd100, 32'd3, TAG_W'(4), 32'd0, 0, 1'b0);
    repeat (15) @(negedge clock);
    #2 reset = 1'b1;
    #6 reset = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("post_rst_mdu_valid", 32'(mdu_valid), 32'd0);
    repeat (40) @(negedge clock);
    applyStimulus(DIV_OP_REMU, 32'd17, 32'd5, TAG_W'(11), 32'd2, 33, 1'b1);
    waitIdle();

    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("mdu2alu_quiet", 32'(mdu2aluViol), 32'd0);
    checkOutput("alu_gnt_rule", 32'(gntViol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
